// File: rtl/rv32v_elem_sequencer.sv
// Two-lane vector element sequencer: walks [vstart, vl) two elements
// per cycle, emitting lane indices, enables and destination offsets.
module rv32v_elem_sequencer #(
    parameter int VLMAX = 128,
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             dec_valid_i,
    output logic             dec_ready_o,
    input  logic [IDX_W-1:0] vl_i,
    input  logic [IDX_W-1:0] vstart_i,
    input  logic             mask_ena_i,
    input  logic [VLMAX-1:0] v0_mask_i,
    input  logic             vd_widen_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             elem_valid_o,
    output logic [IDX_W-1:0] elem_idx0_o,
    output logic [IDX_W-1:0] elem_idx1_o,
    output logic             lane_en0_o,
    output logic             lane_en1_o,
    output logic [IDX_W-1:0] woffset0_o,
    output logic [IDX_W-1:0] woffset1_o,
    output logic             elem_last_o,
    output logic             op_done_o,
    output logic [IDX_W-1:0] resume_idx_o
);

    localparam int MW = $clog2(VLMAX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e state_q, state_d;

    // One extra bit so e+2 past vl never wraps.
    logic [IDX_W:0]   e_q, e_d, e_nxt;
    logic [IDX_W-1:0] vl_q;
    logic [IDX_W-1:0] resume_q, resume_d;
    logic             mena_q;
    logic             widen_q;
    logic [VLMAX-1:0] mask_q;
    logic [IDX_W-1:0] idx0, idx1;
    logic             last;
    logic             accept;

    function automatic logic lane_on(
        input logic [IDX_W-1:0] idx,
        input logic [IDX_W-1:0] vl,
        input logic             mena,
        input logic [VLMAX-1:0] mask
    );
        logic bit_on;
        bit_on = (idx < IDX_W'(VLMAX)) ? mask[idx[MW-1:0]] : 1'b0;
        return (idx < vl) && (!mena || bit_on);
    endfunction

    function automatic logic [IDX_W-1:0] woff(
        input logic [IDX_W-1:0] idx,
        input logic             widen
    );
        return widen ? (idx << 1) : idx;
    endfunction

    assign idx0   = e_q[IDX_W-1:0];
    assign idx1   = idx0 + IDX_W'(1);
    assign e_nxt  = e_q + (IDX_W+1)'(2);
    assign last   = e_nxt >= {1'b0, vl_q};
    assign accept = (state_q == IDLE) && dec_valid_i && !flush_i;

    always_comb begin
        state_d      = state_q;
        e_d          = e_q;
        resume_d     = resume_q;
        dec_ready_o  = 1'b0;
        elem_valid_o = 1'b0;
        elem_idx0_o  = '0;
        elem_idx1_o  = '0;
        lane_en0_o   = 1'b0;
        lane_en1_o   = 1'b0;
        woffset0_o   = '0;
        woffset1_o   = '0;
        elem_last_o  = 1'b0;
        op_done_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                dec_ready_o = 1'b1;
                if (accept) begin
                    e_d     = {1'b0, vstart_i};
                    state_d = (vstart_i >= vl_i) ? DONE : RUN;
                end
            end
            RUN: begin
                elem_idx0_o = idx0;
                elem_idx1_o = idx1;
                lane_en0_o  = lane_on(idx0, vl_q, mena_q, mask_q);
                lane_en1_o  = lane_on(idx1, vl_q, mena_q, mask_q);
                woffset0_o  = woff(idx0, widen_q);
                woffset1_o  = woff(idx1, widen_q);
                elem_last_o = last;
                if (flush_i) begin
                    resume_d = idx0;
                    state_d  = IDLE;
                end else if (!stall_i) begin
                    elem_valid_o = 1'b1;
                    e_d          = e_nxt;
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                if (!flush_i) begin
                    op_done_o = 1'b1;
                    resume_d  = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q  <= IDLE;
            e_q      <= '0;
            resume_q <= '0;
            vl_q     <= '0;
            mena_q   <= 1'b0;
            widen_q  <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            resume_q <= resume_d;
            if (accept) begin
                vl_q    <= vl_i;
                mena_q  <= mask_ena_i;
                widen_q <= vd_widen_i;
                mask_q  <= v0_mask_i;
            end
        end
    end

    assign resume_idx_o = resume_q;

endmodule
